// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states,
// and the divide-by-zero quotient constant.
package muldiv_pkg;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_datapath.sv
// Product / remainder / quotient registers with one shift-add and one
// restoring-divide step per cycle; the final result is selected and sign-corrected here.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [1:0]       op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, mcand_q, dvsr_q, quo_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH:0]     rem_q;
  logic               bz_q, neg_q, nrem_q;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum, shifted, trial;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_lo, rem_s;

  assign mag_a = (sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b = (sgn && b[WIDTH-1]) ? -b : b;

  // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  assign add_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

  // Divide: the trial subtract borrows (top bit set) when the shifted remainder is below the divisor.
  assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= OP_MUL;
      a_q     <= '0;
      mcand_q <= '0;
      dvsr_q  <= '0;
      quo_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      bz_q    <= 1'b0;
      neg_q   <= 1'b0;
      nrem_q  <= 1'b0;
    end else if (load) begin
      op_q    <= op;
      a_q     <= a;
      mcand_q <= mag_a;
      dvsr_q  <= mag_b;
      quo_q   <= mag_a;
      prod_q  <= {{WIDTH{1'b0}}, mag_b};
      rem_q   <= '0;
      bz_q    <= (b == '0);
      neg_q   <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      nrem_q  <= sgn && a[WIDTH-1];
    end else if (step) begin
      prod_q <= {add_sum, prod_q[WIDTH-1:1]};
      if (trial[WIDTH]) begin
        rem_q <= shifted;
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end else begin
        rem_q <= trial;
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end
    end
  end

  assign rem_lo = rem_q[WIDTH-1:0];
  assign prod_s = neg_q  ? -prod_q : prod_q;
  assign quo_s  = neg_q  ? -quo_q  : quo_q;
  assign rem_s  = nrem_q ? -rem_lo : rem_lo;

  always_comb begin
    result = '0;
    case (op_q)
      OP_MUL:  result = prod_s[WIDTH-1:0];
      OP_MULH: result = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV:  result = bz_q ? DIV0_QUOT[WIDTH-1:0] : quo_s;
      default: result = bz_q ? a_q : rem_s;
    endcase
  end

endmodule

// File: rtl/unidad_muldiv.sv
// Iterative multiply/divide unit feeding the register-bank write port.
// Define MULDIV_SIGNED_EN to add the sgn port and two's-complement semantics.
module unidad_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int NREG  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
`ifdef MULDIV_SIGNED_EN
  input  logic             sgn,
`endif
  input  logic [WIDTH-1:0] OPA,
  input  logic [WIDTH-1:0] OPB,
  input  logic [AW-1:0]    RD,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    WA,
  output logic             WE,
  output logic [WIDTH-1:0] DW
);

  localparam int             CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST   = CW'(WIDTH - 1);
  localparam logic [AW:0]    NREG_L = (AW + 1)'(NREG);

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    rd_q, wa_q;
  logic [WIDTH-1:0] dw_q, result;
  logic             sgn_i, load, step, div0;

`ifdef MULDIV_SIGNED_EN
  assign sgn_i = sgn;
`else
  assign sgn_i = 1'b0;
`endif

  assign load = (state == ST_IDLE) && start;
  assign step = (state == ST_RUN);
  assign div0 = op[1] && (OPB == '0);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_RUN;
      ST_RUN:  if (cnt == LAST) next_state = ST_WB;
      default: next_state = ST_IDLE;
    endcase
  end

  // Divide-by-zero presets the counter to its last value: a single RUN cycle
  // keeps the bank write at the second edge after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      rd_q  <= '0;
      wa_q  <= '0;
      dw_q  <= '0;
    end else begin
      state <= next_state;
      if (load) begin
        cnt  <= div0 ? LAST : '0;
        rd_q <= RD;
      end else if (step) begin
        cnt <= cnt + 1'b1;
      end
      if (state == ST_WB) begin
        wa_q <= rd_q;
        dw_q <= result;
      end
    end
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .op     (op),
    .sgn    (sgn_i),
    .a      (OPA),
    .b      (OPB),
    .result (result)
  );

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_WB);
  assign WE   = done && ({1'b0, rd_q} < NREG_L);
  assign WA   = done ? rd_q : wa_q;
  assign DW   = done ? result : dw_q;

endmodule

// File: tb/tb_unidad_muldiv.sv
// Directed bench for unidad_muldiv: write-back latency, results, busy/done framing,
// ignored restarts, destination guard and mid-operation reset.
module tb_unidad_muldiv;

  localparam int LAT = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
`ifdef MULDIV_SIGNED_EN
  logic        sgn = 1'b0;
`endif
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic [4:0]  rd = '0;
  logic        busy, done, we;
  logic [4:0]  wa;
  logic [31:0] dw;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  unidad_muldiv dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
`ifdef MULDIV_SIGNED_EN
    .sgn   (sgn),
`endif
    .OPA   (opa),
    .OPB   (opb),
    .RD    (rd),
    .busy  (busy),
    .done  (done),
    .WA    (wa),
    .WE    (we),
    .DW    (dw)
  );

  // Present one request for exactly one rising edge, then scramble the inputs.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r);
    @(negedge clk);
    op = o; opa = a; opb = b; rd = r; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    opa = $urandom;
    opb = $urandom;
    rd = 5'($urandom_range(0, 31));
  endtask

  // Sample #1 after each edge for 41 cycles from the accept edge (n=0).
  task automatic observe(input int poke_a, input int poke_b, input int rst_at,
                         output int lat, output int ndone, output int nwe, output int nbusy,
                         output logic [31:0] dw_at, output logic [4:0] wa_at, output logic we_at);
    lat = -1; ndone = 0; nwe = 0; nbusy = 0; dw_at = '0; wa_at = '0; we_at = 1'b0;
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (busy) nbusy++;
      if (we) nwe++;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = n; dw_at = dw; wa_at = wa; we_at = we;
        end
      end
      if (n == poke_a || n == poke_b) begin
        start = 1'b1;
        op = 2'($urandom_range(0, 3));
        opa = $urandom;
        opb = $urandom;
      end else begin
        start = 1'b0;
      end
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", we); end
    total++; if (wa !== 5'd0) begin bad++; $display("FAIL reset_wa got=%0d want=0", wa); end
    total++; if (dw !== 32'd0) begin bad++; $display("FAIL reset_dw got=%h want=0", dw); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    int lat, nd, nw, nb; logic [31:0] d; logic [4:0] a; logic w;
    issue(2'b00, 32'd7, 32'd6, 5'd3);
    observe(-1, -1, -1, lat, nd, nw, nb, d, a, w);
    total++; if (lat !== LAT) begin bad++; $display("FAIL mul_lat got=%0d want=%0d", lat, LAT); end
    total++; if (d !== 32'd42) begin bad++; $display("FAIL mul_dw got=%h want=%h", d, 32'd42); end
    total++; if (a !== 5'd3) begin bad++; $display("FAIL mul_wa got=%0d want=3", a); end
    total++; if (w !== 1'b1) begin bad++; $display("FAIL mul_we got=%b want=1", w); end
    total++; if (nd !== 1) begin bad++; $display("FAIL mul_ndone got=%0d want=1", nd); end
    total++; if (nw !== 1) begin bad++; $display("FAIL mul_nwe got=%0d want=1", nw); end
    total++; if (nb !== LAT + 1) begin bad++; $display("FAIL mul_busy got=%0d want=%0d", nb, LAT + 1); end
  endtask

  task automatic test_mulh();
    int lat, nd, nw, nb; logic [31:0] d; logic [4:0] a; logic w;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
    observe(-1, -1, -1, lat, nd, nw, nb, d, a, w);
    total++; if (d !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mulh_dw got=%h want=fffffffe", d); end
    total++; if (a !== 5'd5) begin bad++; $display("FAIL mulh_wa got=%0d want=5", a); end
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
    observe(-1, -1, -1, lat, nd, nw, nb, d, a, w);
    total++; if (d !== 32'h0000_0001) begin bad++; $display("FAIL mull_dw got=%h want=00000001", d); end
    total++; if (lat !== LAT) begin bad++; $display("FAIL mull_lat got=%0d want=%0d", lat, LAT); end
  endtask

  task automatic test_div();
    int lat, nd, nw, nb; logic [31:0] d; logic [4:0] a; logic w;
    // Restart attempts mid-RUN and during the WB cycle must both be dropped.
    issue(2'b10, 32'd100, 32'd7, 5'd9);
    observe(10, LAT, -1, lat, nd, nw, nb, d, a, w);
    total++; if (d !== 32'd14) begin bad++; $display("FAIL div_dw got=%0d want=14", d); end
    total++; if (lat !== LAT) begin bad++; $display("FAIL div_lat got=%0d want=%0d", lat, LAT); end
    total++; if (nw !== 1) begin bad++; $display("FAIL div_restart_nwe got=%0d want=1", nw); end
    total++; if (nb !== LAT + 1) begin bad++; $display("FAIL div_restart_busy got=%0d want=%0d", nb, LAT + 1); end
    issue(2'b11, 32'd100, 32'd7, 5'd9);
    observe(-1, -1, -1, lat, nd, nw, nb, d, a, w);
    total++; if (d !== 32'd2) begin bad++; $display("FAIL rem_dw got=%0d want=2", d); end
    total++; if (nd !== 1) begin bad++; $display("FAIL rem_ndone got=%0d want=1", nd); end
  endtask

  task automatic test_div0();
    int lat, nd, nw, nb; logic [31:0] d; logic [4:0] a; logic w;
    issue(2'b10, 32'd55, 32'd0, 5'd4);
    observe(-1, -1, -1, lat, nd, nw, nb, d, a, w);
    total++; if (lat !== 1) begin bad++; $display("FAIL div0_lat got=%0d want=1", lat); end
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_dw got=%h want=ffffffff", d); end
    total++; if (nb !== 2) begin bad++; $display("FAIL div0_busy got=%0d want=2", nb); end
    total++; if (w !== 1'b1) begin bad++; $display("FAIL div0_we got=%b want=1", w); end
    issue(2'b11, 32'd55, 32'd0, 5'd4);
    observe(-1, -1, -1, lat, nd, nw, nb, d, a, w);
    total++; if (d !== 32'd55) begin bad++; $display("FAIL rem0_dw got=%0d want=55", d); end
    total++; if (lat !== 1) begin bad++; $display("FAIL rem0_lat got=%0d want=1", lat); end
  endtask

  task automatic test_guard();
    int lat, nd, nw, nb; logic [31:0] d; logic [4:0] a; logic w;
    issue(2'b00, 32'd9, 32'd9, 5'd20);
    observe(-1, -1, -1, lat, nd, nw, nb, d, a, w);
    total++; if (lat !== LAT) begin bad++; $display("FAIL guard_lat got=%0d want=%0d", lat, LAT); end
    total++; if (nd !== 1) begin bad++; $display("FAIL guard_ndone got=%0d want=1", nd); end
    total++; if (nw !== 0) begin bad++; $display("FAIL guard_nwe got=%0d want=0", nw); end
    total++; if (a !== 5'd20) begin bad++; $display("FAIL guard_wa got=%0d want=20", a); end
  endtask

  task automatic test_reset_mid();
    int lat, nd, nw, nb; logic [31:0] d; logic [4:0] a; logic w;
    issue(2'b10, 32'd1000, 32'd3, 5'd6);
    observe(-1, -1, 10, lat, nd, nw, nb, d, a, w);
    total++; if (nd !== 0) begin bad++; $display("FAIL rstmid_ndone got=%0d want=0", nd); end
    total++; if (nw !== 0) begin bad++; $display("FAIL rstmid_nwe got=%0d want=0", nw); end
    total++; if (nb !== 11) begin bad++; $display("FAIL rstmid_busy got=%0d want=11", nb); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b want=0", busy); end
    total++; if (dw !== 32'd0) begin bad++; $display("FAIL rstmid_dw got=%h want=0", dw); end
    issue(2'b00, 32'd12345, 32'd1000, 5'd7);
    observe(-1, -1, -1, lat, nd, nw, nb, d, a, w);
    total++; if (d !== 32'd12345000) begin bad++; $display("FAIL fresh_dw got=%0d want=12345000", d); end
    total++; if (lat !== LAT) begin bad++; $display("FAIL fresh_lat got=%0d want=%0d", lat, LAT); end
  endtask

`ifdef MULDIV_SIGNED_EN
  task automatic test_signed();
    int lat, nd, nw, nb; logic [31:0] d; logic [4:0] a; logic w;
    sgn = 1'b1;
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd1);
    observe(-1, -1, -1, lat, nd, nw, nb, d, a, w);
    total++; if (d !== 32'hFFFF_FFFD) begin bad++; $display("FAIL sdiv_dw got=%h want=fffffffd", d); end
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd1);
    observe(-1, -1, -1, lat, nd, nw, nb, d, a, w);
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL srem_dw got=%h want=ffffffff", d); end
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2);
    observe(-1, -1, -1, lat, nd, nw, nb, d, a, w);
    total++; if (d !== 32'h8000_0000) begin bad++; $display("FAIL sovf_dw got=%h want=80000000", d); end
    total++; if (lat !== LAT) begin bad++; $display("FAIL sovf_lat got=%0d want=%0d", lat, LAT); end
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2);
    observe(-1, -1, -1, lat, nd, nw, nb, d, a, w);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL sovf_rem got=%h want=0", d); end
    issue(2'b00, 32'hFFFF_FFFD, 32'd4, 5'd3);
    observe(-1, -1, -1, lat, nd, nw, nb, d, a, w);
    total++; if (d !== 32'hFFFF_FFF4) begin bad++; $display("FAIL smul_dw got=%h want=fffffff4", d); end
    sgn = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_div0();
    test_guard();
    test_reset_mid();
`ifdef MULDIV_SIGNED_EN
    test_signed();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
